// File: rtl/fir_cmac_accumulator.sv
// Complex multiply-accumulate back end for the symmetric FIR.
// Each accepted beat carries LANES pre-added complex samples and their
// coefficients. The lanes are multiplied, summed and accumulated over one
// frame. The full-precision complex result is presented through a
// valid/ready output register.
module fir_cmac_accumulator #(
  parameter int S_WIDTH   = 24,
  parameter int C_WIDTH   = 27,
  parameter int LANES     = 5,
  parameter int ACC_WIDTH = 57
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_busy,
  input  logic                       in_last,
  input  logic [S_WIDTH*LANES-1:0]   samp_inI,
  input  logic [S_WIDTH*LANES-1:0]   samp_inQ,
  input  logic [C_WIDTH*LANES-1:0]   coef_inI,
  input  logic [C_WIDTH*LANES-1:0]   coef_inQ,
  output logic [ACC_WIDTH-1:0]       out_I,
  output logic [ACC_WIDTH-1:0]       out_Q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic                       frame_abort
);

  localparam int P_WIDTH = S_WIDTH + C_WIDTH;

  // Sign-extend one full-precision lane product to accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [P_WIDTH-1:0] p);
    return {{(ACC_WIDTH-P_WIDTH){p[P_WIDTH-1]}}, p};
  endfunction

  // Frame tracking
  logic in_frame_q, in_frame_d;
  logic abort, kill_p1, kill_p2, kill_p3;

  // Stage 1: registered inputs and beat flags
  logic                     vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
  logic [S_WIDTH*LANES-1:0] samp_i_p1_q, samp_i_p1_d, samp_q_p1_q, samp_q_p1_d;
  logic [C_WIDTH*LANES-1:0] coef_i_p1_q, coef_i_p1_d, coef_q_p1_q, coef_q_p1_d;

  // Stage 2: per-lane products
  logic                      vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
  logic signed [P_WIDTH-1:0] prod_ii_p2_q [LANES];
  logic signed [P_WIDTH-1:0] prod_ii_p2_d [LANES];
  logic signed [P_WIDTH-1:0] prod_qq_p2_q [LANES];
  logic signed [P_WIDTH-1:0] prod_qq_p2_d [LANES];
  logic signed [P_WIDTH-1:0] prod_iq_p2_q [LANES];
  logic signed [P_WIDTH-1:0] prod_iq_p2_d [LANES];
  logic signed [P_WIDTH-1:0] prod_qi_p2_q [LANES];
  logic signed [P_WIDTH-1:0] prod_qi_p2_d [LANES];

  // Stage 3: lane sums
  logic                        vld_p3_q, vld_p3_d, first_p3_q, first_p3_d, last_p3_q, last_p3_d;
  logic signed [ACC_WIDTH-1:0] sum_re_p3_q, sum_re_p3_d, sum_im_p3_q, sum_im_p3_d;

  // Stage 4: accumulator and output register
  logic                        acc_en, load;
  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [ACC_WIDTH-1:0] acc_next_re, acc_next_im;
  logic signed [ACC_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic                        out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                        frame_abort_q, frame_abort_d;

  // Abort kills only beats younger than the most recent last beat in flight,
  // so that a just-finished frame still drains to the output.
  always_comb begin
    abort         = in_frame_q & ~in_busy;
    kill_p1       = abort   & ~(vld_p1_q & last_p1_q);
    kill_p2       = kill_p1 & ~(vld_p2_q & last_p2_q);
    kill_p3       = kill_p2 & ~(vld_p3_q & last_p3_q);
    in_frame_d    = in_busy ? ~in_last : 1'b0;
    frame_abort_d = abort;
  end

  // ---- stage p1 boundary ----
  // Capture every beat offered while the controller is busy.
  always_comb begin
    vld_p1_d    = in_busy;
    first_p1_d  = in_busy & ~in_frame_q;
    last_p1_d   = in_busy & in_last;
    samp_i_p1_d = samp_inI;
    samp_q_p1_d = samp_inQ;
    coef_i_p1_d = coef_inI;
    coef_q_p1_d = coef_inQ;
  end

  // ---- stage p2 boundary ----
  // Four full-precision signed products per lane.
  always_comb begin
    vld_p2_d   = vld_p1_q & ~kill_p1;
    first_p2_d = first_p1_q;
    last_p2_d  = last_p1_q;
    for (int k = 0; k < LANES; k++) begin
      prod_ii_p2_d[k] = $signed(samp_i_p1_q[k*S_WIDTH +: S_WIDTH]) * $signed(coef_i_p1_q[k*C_WIDTH +: C_WIDTH]);
      prod_qq_p2_d[k] = $signed(samp_q_p1_q[k*S_WIDTH +: S_WIDTH]) * $signed(coef_q_p1_q[k*C_WIDTH +: C_WIDTH]);
      prod_iq_p2_d[k] = $signed(samp_i_p1_q[k*S_WIDTH +: S_WIDTH]) * $signed(coef_q_p1_q[k*C_WIDTH +: C_WIDTH]);
      prod_qi_p2_d[k] = $signed(samp_q_p1_q[k*S_WIDTH +: S_WIDTH]) * $signed(coef_i_p1_q[k*C_WIDTH +: C_WIDTH]);
    end
  end

  // ---- stage p3 boundary ----
  // Form each lane's complex product and sum across lanes.
  always_comb begin
    vld_p3_d    = vld_p2_q & ~kill_p2;
    first_p3_d  = first_p2_q;
    last_p3_d   = last_p2_q;
    sum_re_p3_d = '0;
    sum_im_p3_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_re_p3_d = sum_re_p3_d + (sext_prod(prod_ii_p2_q[k]) - sext_prod(prod_qq_p2_q[k]));
      sum_im_p3_d = sum_im_p3_d + (sext_prod(prod_iq_p2_q[k]) + sext_prod(prod_qi_p2_q[k]));
    end
  end

  // ---- stage p4 boundary ----
  // Accumulate over the frame and publish the total on the last beat.
  always_comb begin
    acc_en      = vld_p3_q & ~kill_p3;
    load        = acc_en & last_p3_q;
    acc_next_re = first_p3_q ? sum_re_p3_q : acc_re_q + sum_re_p3_q;
    acc_next_im = first_p3_q ? sum_im_p3_q : acc_im_q + sum_im_p3_q;
    acc_re_d    = acc_en ? acc_next_re : acc_re_q;
    acc_im_d    = acc_en ? acc_next_im : acc_im_q;
    out_re_d    = load ? acc_next_re : out_re_q;
    out_im_d    = load ? acc_next_im : out_im_q;
    out_valid_d = out_valid_q;
    if (load)
      out_valid_d = 1'b1;
    else if (out_valid_q & out_ready)
      out_valid_d = 1'b0;
    overrun_d   = overrun_q | (load & out_valid_q & ~out_ready);
  end

  // All pipeline and output state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_frame_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      vld_p1_q      <= 1'b0;
      first_p1_q    <= 1'b0;
      last_p1_q     <= 1'b0;
      samp_i_p1_q   <= '0;
      samp_q_p1_q   <= '0;
      coef_i_p1_q   <= '0;
      coef_q_p1_q   <= '0;
      vld_p2_q      <= 1'b0;
      first_p2_q    <= 1'b0;
      last_p2_q     <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        prod_ii_p2_q[k] <= '0;
        prod_qq_p2_q[k] <= '0;
        prod_iq_p2_q[k] <= '0;
        prod_qi_p2_q[k] <= '0;
      end
      vld_p3_q      <= 1'b0;
      first_p3_q    <= 1'b0;
      last_p3_q     <= 1'b0;
      sum_re_p3_q   <= '0;
      sum_im_p3_q   <= '0;
      acc_re_q      <= '0;
      acc_im_q      <= '0;
      out_re_q      <= '0;
      out_im_q      <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      in_frame_q    <= in_frame_d;
      frame_abort_q <= frame_abort_d;
      vld_p1_q      <= vld_p1_d;
      first_p1_q    <= first_p1_d;
      last_p1_q     <= last_p1_d;
      samp_i_p1_q   <= samp_i_p1_d;
      samp_q_p1_q   <= samp_q_p1_d;
      coef_i_p1_q   <= coef_i_p1_d;
      coef_q_p1_q   <= coef_q_p1_d;
      vld_p2_q      <= vld_p2_d;
      first_p2_q    <= first_p2_d;
      last_p2_q     <= last_p2_d;
      prod_ii_p2_q  <= prod_ii_p2_d;
      prod_qq_p2_q  <= prod_qq_p2_d;
      prod_iq_p2_q  <= prod_iq_p2_d;
      prod_qi_p2_q  <= prod_qi_p2_d;
      vld_p3_q      <= vld_p3_d;
      first_p3_q    <= first_p3_d;
      last_p3_q     <= last_p3_d;
      sum_re_p3_q   <= sum_re_p3_d;
      sum_im_p3_q   <= sum_im_p3_d;
      acc_re_q      <= acc_re_d;
      acc_im_q      <= acc_im_d;
      out_re_q      <= out_re_d;
      out_im_q      <= out_im_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_I       = out_re_q;
  assign out_Q       = out_im_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_fir_cmac_accumulator.sv
// Scoreboard bench for fir_cmac_accumulator: a frame-level complex
// dot-product model queues expected results; a monitor pops on each transfer.
module tb_fir_cmac_accumulator;
  localparam int S = 24;
  localparam int C = 27;
  localparam int L = 5;
  localparam int A = 57;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_busy = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [S*L-1:0] samp_inI = '0;
  logic [S*L-1:0] samp_inQ = '0;
  logic [C*L-1:0] coef_inI = '0;
  logic [C*L-1:0] coef_inQ = '0;
  logic [A-1:0] out_I, out_Q;
  logic out_valid, overrun, frame_abort;

  int n_tests = 0;
  int n_fail = 0;

  int sI[L], sQ[L], cI[L], cQ[L];
  longint exp_re[$];
  longint exp_im[$];
  bit     m_in_frame = 1'b0;
  longint m_re = 0, m_im = 0;
  int     m_aborts = 0;
  int     abort_seen = 0;

  fir_cmac_accumulator #(.S_WIDTH(S), .C_WIDTH(C), .LANES(L), .ACC_WIDTH(A)) dut (
    .clk(clk), .reset(reset), .in_busy(in_busy), .in_last(in_last),
    .samp_inI(samp_inI), .samp_inQ(samp_inQ), .coef_inI(coef_inI), .coef_inQ(coef_inQ),
    .out_I(out_I), .out_Q(out_Q), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  task automatic set_all(input int si, input int sq, input int ci, input int cq);
    for (int k = 0; k < L; k++) begin
      sI[k] = si; sQ[k] = sq; cI[k] = ci; cQ[k] = cq;
    end
  endtask

  // Frame-level reference: a frame's result is the sum over its beats of
  // sum_k (sI + j sQ)(cI + j cQ); leaving busy mid-frame discards it.
  task automatic model_step(input bit busy, input bit last);
    if (busy) begin
      if (!m_in_frame) begin
        m_re = 0;
        m_im = 0;
      end
      for (int k = 0; k < L; k++) begin
        m_re += longint'(sI[k]) * longint'(cI[k]) - longint'(sQ[k]) * longint'(cQ[k]);
        m_im += longint'(sI[k]) * longint'(cQ[k]) + longint'(sQ[k]) * longint'(cI[k]);
      end
      if (last) begin
        exp_re.push_back(m_re);
        exp_im.push_back(m_im);
      end
      m_in_frame = !last;
    end else if (m_in_frame) begin
      m_aborts++;
      m_in_frame = 1'b0;
    end
  endtask

  // Present one beat, update the model, and advance one edge.
  task automatic beat(input bit busy, input bit last);
    for (int k = 0; k < L; k++) begin
      samp_inI[k*S +: S] = sI[k][S-1:0];
      samp_inQ[k*S +: S] = sQ[k][S-1:0];
      coef_inI[k*C +: C] = cI[k][C-1:0];
      coef_inQ[k*C +: C] = cQ[k][C-1:0];
    end
    in_busy = busy;
    in_last = last;
    model_step(busy, last);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_all(0, 0, 0, 0);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0);
  endtask

  // Monitor: every transfer must match the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (frame_abort) abort_seen++;
        if (out_valid && out_ready) begin
          if (exp_re.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got out_I=%0d out_Q=%0d, required no result", $signed(out_I), $signed(out_Q));
          end else begin
            check("result_I", $signed(out_I), exp_re.pop_front());
            check("result_Q", $signed(out_Q), exp_im.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    longint big;
    set_all(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_I", out_I, 0);
    check("rst_out_Q", out_Q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_abort", frame_abort, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic accumulate and latency
    set_all(1, 0, 2, 0);
    beat(1, 0); beat(1, 0); beat(1, 1);
    set_all(0, 0, 0, 0);
    beat(0, 0);
    check("lat_n1_valid", out_valid, 0);
    beat(0, 0);
    check("lat_n2_valid", out_valid, 0);
    beat(0, 0);
    check("lat_n3_valid", out_valid, 1);
    check("basic_out_I", $signed(out_I), 30);
    check("basic_out_Q", $signed(out_Q), 0);
    idle(2);

    // Complex product on lane 0
    set_all(0, 0, 0, 0);
    sI[0] = 3; sQ[0] = 4; cI[0] = 1; cQ[0] = 2;
    beat(1, 0); beat(1, 0); beat(1, 1);
    idle(3);
    check("cplx_out_I", $signed(out_I), -15);
    check("cplx_out_Q", $signed(out_Q), 30);
    idle(2);

    // Abort of a partial frame followed by a good frame
    set_all(1, 0, 2, 0);
    beat(1, 0); beat(1, 0);
    idle(1);
    check("abort_pulse", frame_abort, 1);
    set_all(0, 0, 0, 0);
    sI[0] = 1; cI[0] = 1;
    beat(1, 0);
    check("abort_pulse_end", frame_abort, 0);
    beat(1, 0); beat(1, 1);
    idle(3);
    check("abort_out_I", $signed(out_I), 3);
    idle(2);
    check("abort_count", abort_seen, m_aborts);

    // Backpressure across two back-to-back frames
    out_ready = 1'b0;
    set_all(1, 0, 2, 0);
    beat(1, 0); beat(1, 0); beat(1, 1);
    void'(exp_re.pop_back());
    void'(exp_im.pop_back());
    set_all(1, 0, 1, 0);
    beat(1, 0); beat(1, 0); beat(1, 1);
    idle(4);
    check("bp_out_I", $signed(out_I), 15);
    check("bp_out_valid", out_valid, 1);
    check("bp_overrun", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    check("bp_valid_drop", out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);

    // Extremes
    set_all(-(1 << 23), 0, -(1 << 26), 0);
    beat(1, 0); beat(1, 0); beat(1, 1);
    idle(3);
    big = 64'sd15 <<< 49;
    check("ext1_out_I", $signed(out_I), big);
    idle(2);
    set_all(0, -(1 << 23), 0, (1 << 26) - 1);
    beat(1, 0); beat(1, 0); beat(1, 1);
    idle(3);
    big = 64'sd15 * (64'sd1 <<< 23) * ((64'sd1 <<< 26) - 1);
    check("ext2_out_I", $signed(out_I), big);
    check("ext2_out_Q", $signed(out_Q), 0);
    idle(2);

    // Reset in the middle of a frame
    set_all(1, 0, 2, 0);
    beat(1, 0);
    in_busy = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_out_I", out_I, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_pending", exp_re.size(), 0);
    m_in_frame = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_busy = 1'b0;
    set_all(0, 0, 0, 0);
    sI[0] = 5; sQ[0] = 2; cI[0] = -3; cQ[0] = 7;
    beat(1, 0); beat(1, 0); beat(1, 1);
    idle(3);
    check("post_rst_out_I", $signed(out_I), -87);
    check("post_rst_out_Q", $signed(out_Q), 87);
    idle(2);

    // Randomized beats, frames and aborts
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < L; k++) begin
        sI[k] = int'($urandom) >>> 8;
        sQ[k] = int'($urandom) >>> 8;
        cI[k] = int'($urandom) >>> 5;
        cQ[k] = int'($urandom) >>> 5;
      end
      beat($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 30);
    end
    idle(6);
    for (int i = 0; i < 20 && exp_re.size() != 0; i++) idle(1);
    check("drain_empty", exp_re.size(), 0);
    check("rand_abort_count", abort_seen, m_aborts);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
